ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port command-driven RAM between two requesters. Each granted
//  transaction becomes the RAM's 10-bit command sequence, driven on din/rx_valid:
//  00=wr addr, 01=wr data, 10=rd addr, 11=read. Read data is returned to the owner.
//  Sits between the SPI-slave command path (req0) and a local host port (req1).
// PARAMETERS
//  ADDR_SIZE  8  RAM address/data width; RAM command word is ADDR_SIZE+2 bits
//  FIXED_PRI  0  0 = round-robin; 1 = requester 0 always wins
//  TIMEOUT    4  max R_WAIT cycles without ram_tx_valid before error completion
// PORTS
//  clk           in   1            clock, rising edge
//  rst_n         in   1            async active-low reset
//  req0/req1     in   1            transaction request
//  we0/we1       in   1            1 = write, 0 = read
//  addr0/addr1   in   ADDR_SIZE    target address
//  wdata0/wdata1 in   ADDR_SIZE    write data
//  gnt0/gnt1     out  1            1-cycle pulse: request accepted, fields sampled
//  ack0/ack1     out  1            1-cycle pulse: transaction complete
//  rdata0/rdata1 out  ADDR_SIZE    read data, valid with ack; held until next read ack
//  err0/err1     out  1            with ack: read timed out, rdata not updated
//  ram_din       out  ADDR_SIZE+2  command word to RAM
//  ram_rx_valid  out  1            command valid to RAM
//  ram_dout      in   ADDR_SIZE    RAM read data
//  ram_tx_valid  in   1            RAM read data valid
// BEHAVIOUR
//  Reset: state IDLE; gnt*/ack*/err*/ram_rx_valid = 0; rdata* = 0; ram_din = 0;
//   RR pointer = "last granted 1" (req0 wins first tie).
//  IDLE: ram_din = {2'b00,0}, ram_rx_valid = 0. ram_din[9:8] is never 2'b11 outside
//   R_CMD, because the RAM performs a read on 11 regardless of rx_valid.
//  Arbitration (IDLE only): a single req wins. Both requesting: FIXED_PRI=1 -> 0;
//   else the requester not granted last. Pointer updates on grant only.
//   gnt is combinational in the IDLE cycle; we/addr/wdata latched on that edge.
//   Requester may drop req after gnt; req held through ack is a new request.
//  FSM (one RAM command per cycle, ram_rx_valid = 1 in every non-IDLE command state):
//   IDLE -> W_ADDR (we=1) | R_ADDR (we=0)
//   W_ADDR: din={00,addr} -> W_DATA
//   W_DATA: din={01,wdata} -> IDLE; ack(owner) registered, asserted next cycle
//   R_ADDR: din={10,addr} -> R_CMD
//   R_CMD : din={11,0} -> R_WAIT
//   R_WAIT: rx_valid=0, din={00,0}; ram_tx_valid=1 -> rdata<=ram_dout, ack -> IDLE;
//           else count; TIMEOUT cycles with no tx_valid -> ack+err, -> IDLE
//  Latency (gnt at cycle T): write ack at T+3; read ack at T+4 (no timeout).
//  Back-to-back: the IDLE cycle that carries an ack may grant again.
//  Only the owner's ack/err/rdata change; the other port's outputs hold.
//  Reset mid-transaction: abort immediately, no ack issued. RAM sees only the
//   commands already issued; a write is committed iff W_DATA completed.
// TESTING
//  1. req0 write addr 0x3C data 0xA5 -> gnt0 @T; din 0x03C @T+1, 0x1A5 @T+2; ack0 @T+3
//  2. req1 read 0x3C after test 1 -> din 0x23C, 0x300; ack1 @T+4, rdata1=0xA5, err1=0
//  3. req0+req1 held, RR -> grants 0,1,0,1; FIXED_PRI=1 -> req0 every grant, req1 starves
//  4. ram_tx_valid tied 0 on read -> ack+err after TIMEOUT R_WAIT cycles, rdata unchanged
//  5. rst_n low during W_DATA of write 0x10<-0x77 -> no ack; FSM IDLE; then a read of 0x10 returns 0x77
//  6. Idle 20 cycles, no req -> ram_rx_valid=0, ram_din[9:8]=00 every cycle, RAM tx_valid unchanged

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Purpose : two-requester arbiter that turns one granted transaction at a time
//           into the single-port RAM's 10-bit command sequence and returns read data.
// Latency : gnt combinational in IDLE; write ack at gnt+3, read ack at gnt+4 (or gnt+3+TIMEOUT with err).
// Backpressure: requests wait while a transaction is in flight; gnt only in IDLE, ack
//           cycle may grant again. Round-robin (or fixed priority to req0) on ties.
//
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   req*, we*, addr*, wdata*   requester side; fields sampled on the gnt edge
//   gnt*, ack*, err*, rdata*   per-requester grant pulse, completion pulse, timeout flag, read data
//   ram_din, ram_rx_valid      command word and valid toward the RAM
//   ram_dout, ram_tx_valid     read data and valid from the RAM
module ram_port_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int FIXED_PRI = 0,
    parameter int TIMEOUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [ADDR_SIZE-1:0] wdata0,
    input  logic [ADDR_SIZE-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [ADDR_SIZE-1:0] rdata0,
    output logic [ADDR_SIZE-1:0] rdata1,
    output logic                 err0,
    output logic                 err1,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        R_ADDR = 3'd3,
        R_CMD  = 3'd4,
        R_WAIT = 3'd5
    } state_t;

    state_t                 state;
    logic                   owner;      // 0 = req0 owns the current transaction
    logic                   last_gnt;   // round-robin pointer: requester granted most recently
    logic [ADDR_SIZE-1:0]   wdata_q;
    logic [CNT_W-1:0]       wait_cnt;

    logic                   sel_we;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [ADDR_SIZE-1:0]   sel_wdata;

    // Grant is only offered in IDLE so the requester sees it in the same cycle
    // its fields are sampled.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (req0 && req1) begin
                if ((FIXED_PRI != 0) || last_gnt)
                    gnt0 = 1'b1;
                else
                    gnt1 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign sel_we    = gnt1 ? we1    : we0;
    assign sel_addr  = gnt1 ? addr1  : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;

    // ram_din/ram_rx_valid are registered: each transition loads the command
    // belonging to the state being entered. Leaving R_CMD clears the opcode so
    // the RAM never sees 2'b11 (it reads on 11 even without rx_valid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_gnt     <= 1'b1;
            wdata_q      <= '0;
            wait_cnt     <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner        <= gnt1;
                        last_gnt     <= gnt1;
                        wdata_q      <= sel_wdata;
                        ram_rx_valid <= 1'b1;
                        if (sel_we) begin
                            ram_din <= {2'b00, sel_addr};
                            state   <= W_ADDR;
                        end else begin
                            ram_din <= {2'b10, sel_addr};
                            state   <= R_ADDR;
                        end
                    end else begin
                        ram_din      <= '0;
                        ram_rx_valid <= 1'b0;
                    end
                end
                W_ADDR: begin
                    ram_din <= {2'b01, wdata_q};
                    state   <= W_DATA;
                end
                W_DATA: begin
                    ram_din      <= '0;
                    ram_rx_valid <= 1'b0;
                    if (owner) ack1 <= 1'b1;
                    else       ack0 <= 1'b1;
                    state        <= IDLE;
                end
                R_ADDR: begin
                    ram_din <= {2'b11, {ADDR_SIZE{1'b0}}};
                    state   <= R_CMD;
                end
                R_CMD: begin
                    ram_din      <= '0;
                    ram_rx_valid <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= R_WAIT;
                end
                R_WAIT: begin
                    if (ram_tx_valid) begin
                        if (owner) begin
                            rdata1 <= ram_dout;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= ram_dout;
                            ack0   <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Give up: complete with err, leave rdata untouched.
                        if (owner) begin
                            ack1 <= 1'b1;
                            err1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                            err0 <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    ram_din      <= '0;
                    ram_rx_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_tx_valid = 1'b0;

    // Second instance with fixed priority; no RAM behind it, writes only.
    logic       fp_req0, fp_req1;
    logic       fp_gnt0, fp_gnt1, fp_ack0, fp_ack1, fp_err0, fp_err1;
    logic [7:0] fp_rdata0, fp_rdata1;
    logic [9:0] fp_din;
    logic       fp_rx_valid;

    int checks = 0;
    int errors = 0;

    // RAM behaviour model control
    logic       ram_clr;
    logic       tx_kill;
    logic [7:0] mem [256];
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] rd_addr = 8'h00;

    ram_port_arbiter #(.ADDR_SIZE(8), .FIXED_PRI(0), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    ram_port_arbiter #(.ADDR_SIZE(8), .FIXED_PRI(1), .TIMEOUT(4)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(fp_req0), .req1(fp_req1), .we0(1'b1), .we1(1'b1),
        .addr0(8'h40), .addr1(8'h41), .wdata0(8'h11), .wdata1(8'h22),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .ack0(fp_ack0), .ack1(fp_ack1),
        .rdata0(fp_rdata0), .rdata1(fp_rdata1), .err0(fp_err0), .err1(fp_err1),
        .ram_din(fp_din), .ram_rx_valid(fp_rx_valid),
        .ram_dout(8'h00), .ram_tx_valid(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command-driven single-port RAM: opcode 11 reads whether or not rx_valid is set.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            ram_tx_valid <= 1'b0;
        end else begin
            if (ram_rx_valid) begin
                case (ram_din[9:8])
                    2'b00: wr_addr <= ram_din[7:0];
                    2'b01: mem[wr_addr] <= ram_din[7:0];
                    2'b10: rd_addr <= ram_din[7:0];
                    default: ;
                endcase
            end
            if (ram_din[9:8] == 2'b11 && !tx_kill) begin
                ram_tx_valid <= 1'b1;
                ram_dout     <= mem[rd_addr];
            end else begin
                ram_tx_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge, check the combinational grant, then drop
    // req and scramble the fields to show they were latched. Returns at gnt+1.
    task automatic start_txn(input logic p, input logic w, input logic [7:0] a,
                             input logic [7:0] d, input string tag);
        @(negedge clk);
        if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        #1;
        chk({tag, "_gnt"}, p ? gnt1 : gnt0, 1);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        addr0 = ~a; addr1 = ~a; wdata0 = ~d; wdata1 = ~d;
    endtask

    // Cycles from grant to ack, or -1 if the bound expires.
    task automatic wait_ack(input logic p, input int max, output int n);
        n = -1;
        for (int i = 2; i <= max; i++) begin
            @(negedge clk);
            if ((p ? ack1 : ack0) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; ram_clr = 1'b1; tx_kill = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        fp_req0 = 0; fp_req1 = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", {gnt0, gnt1, ack0, ack1, err0, err1, ram_rx_valid}, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        rst_n = 1'b1; ram_clr = 1'b0;
        @(negedge clk);

        // 1: req0 write 0x3C <- 0xA5
        start_txn(0, 1, 8'h3C, 8'hA5, "t1");
        chk("t1_din_waddr", ram_din, 10'h03C);
        chk("t1_rxv", ram_rx_valid, 1);
        @(negedge clk);
        chk("t1_din_wdata", ram_din, 10'h1A5);
        chk("t1_noack_early", ack0, 0);
        @(negedge clk);
        chk("t1_ack0", {ack0, err0, ack1}, 3'b100);
        chk("t1_idle_din", {ram_rx_valid, ram_din}, 0);
        @(negedge clk);
        chk("t1_ack_pulse", ack0, 0);

        // 2: req1 read 0x3C
        start_txn(1, 0, 8'h3C, 8'h00, "t2");
        chk("t2_din_raddr", ram_din, 10'h23C);
        @(negedge clk);
        chk("t2_din_rcmd", ram_din, 10'h300);
        @(negedge clk);
        chk("t2_wait", {ram_rx_valid, ram_din}, 0);
        chk("t2_noack_early", ack1, 0);
        @(negedge clk);
        chk("t2_ack1", {ack1, err1, ack0}, 3'b100);
        chk("t2_rdata1", rdata1, 8'hA5);
        chk("t2_rdata0_hold", rdata0, 8'h00);

        // 3: both held; RR from last=1 gives 0,1,0,1; fixed priority gives only 0
        @(negedge clk);
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        addr0 = 8'h20; addr1 = 8'h21; wdata0 = 8'h5A; wdata1 = 8'hC3;
        fp_req0 = 1; fp_req1 = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("t3_rr_gnt_%0d", i), {gnt1, gnt0},
                (i == 0 || i == 6) ? 2'b01 : ((i == 3 || i == 9) ? 2'b10 : 2'b00));
            chk($sformatf("t3_fp_gnt_%0d", i), {fp_gnt1, fp_gnt0},
                (i % 3 == 0) ? 2'b01 : 2'b00);
            @(negedge clk);
        end
        req0 = 0; req1 = 0; fp_req0 = 0; fp_req1 = 0;
        repeat (2) @(negedge clk);

        // 4: good read by req0, then a read with tx_valid suppressed
        start_txn(0, 0, 8'h3C, 8'h00, "t4a");
        wait_ack(0, 12, n);
        chk("t4a_lat", n, 4);
        chk("t4a_rdata0", {rdata0, err0}, {8'hA5, 1'b0});
        tx_kill = 1'b1;
        start_txn(0, 0, 8'h21, 8'h00, "t4b");
        wait_ack(0, 16, n);
        chk("t4b_lat", n, 3 + 4);
        chk("t4b_err0", err0, 1);
        chk("t4b_rdata0_hold", rdata0, 8'hA5);
        chk("t4b_port1_hold", {ack1, err1, rdata1}, {2'b00, 8'hA5});
        @(negedge clk);
        chk("t4b_err_pulse", {ack0, err0}, 0);
        tx_kill = 1'b0;

        // 5a: reset lands just after the RAM accepted the data word: no ack, data kept
        start_txn(0, 1, 8'h10, 8'h77, "t5a");
        chk("t5a_din_waddr", ram_din, 10'h010);
        @(negedge clk);
        chk("t5a_din_wdata", ram_din, 10'h177);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5a_rst_outs", {ack0, ram_rx_valid, ram_din}, 0);
        @(negedge clk);
        chk("t5a_noack", ack0, 0);
        rst_n = 1'b1;

        // 5b: reset in the middle of W_DATA: data word never reaches the RAM
        start_txn(0, 1, 8'h10, 8'h55, "t5b");
        @(negedge clk);
        chk("t5b_din_wdata", ram_din, 10'h155);
        rst_n = 1'b0;
        #1;
        chk("t5b_rst_din", {ram_rx_valid, ram_din}, 0);
        @(negedge clk);
        chk("t5b_noack", ack0, 0);
        rst_n = 1'b1;

        // FSM back in IDLE: immediate grant, read returns the committed value
        start_txn(1, 0, 8'h10, 8'h00, "t5r");
        wait_ack(1, 12, n);
        chk("t5r_lat", n, 4);
        chk("t5r_rdata1", {rdata1, err1}, {8'h77, 1'b0});

        // 6: idle, no RAM activity
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("t6_idle_%0d", i), {ram_rx_valid, ram_din[9:8], ram_tx_valid}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
